// File: rtl/color_sequencer.sv
// Command sequencer in front of colorGen: decodes a framed byte stream into
// shadow registers, applies them atomically, then freezes them for one full pass.
module color_sequencer #(
  parameter int unsigned HOLD_CYCLES = 232,
  parameter int unsigned SWEEP_DIV   = 50000,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mode_out,
  output logic [7:0] lint_out,
  output logic [7:0] color_idx_out,
  output logic [7:0] white_out,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic       busy,
  output logic       sweep_active,
  output logic       cmd_err
);

  localparam logic [7:0] OP_DIRECT   = 8'h21;
  localparam logic [7:0] OP_INDEX    = 8'hA4;
  localparam logic [7:0] OP_SWEEP    = 8'h5A;
  localparam logic [7:0] OP_OFF      = 8'h00;
  localparam logic [7:0] MODE_DIRECT = 8'h21;
  localparam logic [7:0] MODE_INDEX  = 8'hA4;

  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned PRESC_W = (SWEEP_DIV > 1)   ? $clog2(SWEEP_DIV)   : 1;
  localparam int unsigned GAP_W   = (TIMEOUT > 1)     ? $clog2(TIMEOUT)     : 1;
  localparam logic [HOLD_W-1:0]  HOLD_TC  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(SWEEP_DIV - 1);
  localparam logic [GAP_W-1:0]   GAP_TC   = GAP_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_APPLY, S_SWEEP_STEP, S_HOLD
  } state_t;

  typedef enum logic [1:0] {C_DIRECT, C_INDEX, C_SWEEP} cmd_t;

  state_t state, state_next;
  cmd_t   cmd;

  logic [1:0]         rst_sync;
  logic               rst_n;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [PRESC_W-1:0] presc;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         pay_cnt;
  logic [1:0]         pay_last;
  logic [7:0]         step_reg;

  logic [7:0] sh_mode, sh_lint, sh_idx, sh_w, sh_r, sh_g, sh_b, sh_step;
  logic       sh_sweep;

  logic       accept, tick;
  logic       hdr_load, hdr_off, hdr_bad, pay_wr, gap_to, take_tick;
  logic [8:0] idx_sum;
  logic [7:0] idx_next;

  // Reset asserts asynchronously but releases two clocks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign in_ready = rst_n && ((state == S_IDLE) || (state == S_COLLECT));
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;
  assign tick     = sweep_active && (presc == PRESC_TC);
  assign pay_last = (cmd == C_DIRECT) ? 2'd3 : 2'd2;

  always_comb begin
    idx_sum  = {1'b0, color_idx_out} + {1'b0, step_reg};
    idx_next = (idx_sum >= 9'd216) ? 8'(idx_sum - 9'd216) : idx_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    hdr_load   = 1'b0;
    hdr_off    = 1'b0;
    hdr_bad    = 1'b0;
    pay_wr     = 1'b0;
    gap_to     = 1'b0;
    take_tick  = 1'b0;
    case (state)
      S_IDLE: begin
        // An accepted byte wins; a pending tick waits for a byte-free IDLE cycle.
        if (accept) begin
          case (in_data)
            OP_DIRECT, OP_INDEX, OP_SWEEP: begin
              hdr_load   = 1'b1;
              state_next = S_COLLECT;
            end
            OP_OFF: begin
              hdr_off    = 1'b1;
              state_next = S_APPLY;
            end
            default: hdr_bad = 1'b1;
          endcase
        end else if (tick) begin
          take_tick  = 1'b1;
          state_next = S_SWEEP_STEP;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          pay_wr = 1'b1;
          if (pay_cnt == pay_last) state_next = S_APPLY;
        end else if (gap_cnt == GAP_TC) begin
          gap_to     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_APPLY:      state_next = S_HOLD;
      S_SWEEP_STEP: state_next = S_HOLD;
      S_HOLD:       if (hold_cnt == HOLD_TC) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      gap_cnt  <= '0;
      presc    <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= hdr_bad || gap_to;

      if ((state == S_HOLD) && (hold_cnt != HOLD_TC)) hold_cnt <= hold_cnt + 1'b1;
      else                                           hold_cnt <= '0;

      if ((state == S_COLLECT) && !accept && !gap_to) gap_cnt <= gap_cnt + 1'b1;
      else                                            gap_cnt <= '0;

      if (!sweep_active || take_tick) presc <= '0;
      else if (presc != PRESC_TC)     presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= C_DIRECT;
      pay_cnt  <= '0;
      sh_mode  <= '0;
      sh_lint  <= '0;
      sh_idx   <= '0;
      sh_w     <= '0;
      sh_r     <= '0;
      sh_g     <= '0;
      sh_b     <= '0;
      sh_step  <= '0;
      sh_sweep <= 1'b0;
    end else begin
      // Shadow starts as a copy of the live outputs so unwritten fields persist.
      if (hdr_load || hdr_off) begin
        pay_cnt  <= '0;
        sh_lint  <= lint_out;
        sh_idx   <= color_idx_out;
        sh_w     <= white_out;
        sh_r     <= red_out;
        sh_g     <= green_out;
        sh_b     <= blue_out;
        sh_step  <= step_reg;
        sh_sweep <= (in_data == OP_SWEEP);
        sh_mode  <= (in_data == OP_DIRECT || in_data == OP_OFF) ? MODE_DIRECT : MODE_INDEX;
        cmd      <= (in_data == OP_DIRECT) ? C_DIRECT :
                    (in_data == OP_INDEX)  ? C_INDEX  : C_SWEEP;
        if (hdr_off) begin
          sh_w <= '0;
          sh_r <= '0;
          sh_g <= '0;
          sh_b <= '0;
        end
      end

      if (pay_wr) begin
        pay_cnt <= pay_cnt + 1'b1;
        case (cmd)
          C_DIRECT:
            case (pay_cnt)
              2'd0:    sh_r <= in_data;
              2'd1:    sh_g <= in_data;
              2'd2:    sh_b <= in_data;
              default: sh_w <= in_data;
            endcase
          C_INDEX:
            case (pay_cnt)
              2'd0:    sh_idx  <= in_data;
              2'd1:    sh_w    <= in_data;
              default: sh_lint <= in_data;
            endcase
          default:
            case (pay_cnt)
              2'd0:    sh_step <= in_data;
              2'd1:    sh_w    <= in_data;
              default: sh_lint <= in_data;
            endcase
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_out      <= '0;
      lint_out      <= '0;
      color_idx_out <= '0;
      white_out     <= '0;
      red_out       <= '0;
      green_out     <= '0;
      blue_out      <= '0;
      step_reg      <= '0;
      sweep_active  <= 1'b0;
    end else if (state == S_APPLY) begin
      mode_out      <= sh_mode;
      lint_out      <= sh_lint;
      color_idx_out <= sh_idx;
      white_out     <= sh_w;
      red_out       <= sh_r;
      green_out     <= sh_g;
      blue_out      <= sh_b;
      step_reg      <= sh_step;
      sweep_active  <= sh_sweep;
    end else if (state == S_SWEEP_STEP) begin
      color_idx_out <= idx_next;
    end
  end

endmodule
